// File: rtl/sonic_vc_tx_width_down.sv
// sonic_vc_tx_width_down
// ----------------------
// Splits a 128-bit Avalon-ST packet stream into a 64-bit stream. Each 128-bit
// beat is emitted as two 64-bit words, upper half first. The exception is an
// EOP beat whose second half is entirely unused (empty >= 2). That beat needs
// only one output word.
//
// The block holds a single 128-bit beat. All source-side outputs come straight
// from that holding register and the state, so no combinational path runs from
// the sink inputs to the source outputs. A new sink beat is accepted on the same
// cycle the last word of the held beat leaves. This sustains one sink beat per
// two cycles with no bubble.
//
// Ports
//   clock, reset                  : clock and synchronous active-high reset
//   avalonst_sink_*               : 128-bit input stream (ready latency 0)
//   avalonst_source_*             : 64-bit output stream (ready latency 0)
//   pkt_count                     : number of packets emitted (EOP transfers)
//
// Configuration
//   SONIC_VC_TX_PKT_CNT_EN : when defined, pkt_count is a wrapping 32-bit
//                            counter of emitted EOP words. Otherwise it is
//                            tied to 0 and no counter exists.

module sonic_vc_tx_width_down (
    input  logic         clock,
    input  logic         reset,
    input  logic [127:0] avalonst_sink_data,
    input  logic [1:0]   avalonst_sink_empty,
    input  logic         avalonst_sink_startofpacket,
    input  logic         avalonst_sink_endofpacket,
    input  logic         avalonst_sink_error,
    input  logic         avalonst_sink_valid,
    output logic         avalonst_sink_ready,
    output logic [63:0]  avalonst_source_data,
    output logic         avalonst_source_empty,
    output logic         avalonst_source_startofpacket,
    output logic         avalonst_source_endofpacket,
    output logic         avalonst_source_error,
    output logic         avalonst_source_valid,
    input  logic         avalonst_source_ready,
    output logic [31:0]  pkt_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HI    = 2'd1,
        LO    = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;

    logic [127:0] held_data;
    logic [1:0]   held_empty;
    logic         held_sop;
    logic         held_eop;
    logic         held_error;

    logic         single_out;
    logic         sink_xfer;
    logic         source_xfer;

    // An EOP beat with two or three unused words has nothing in its lower half.
    assign single_out  = held_eop && held_empty[1];

    assign sink_xfer   = avalonst_sink_valid && avalonst_sink_ready;
    assign source_xfer = avalonst_source_valid && avalonst_source_ready;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Holding register. It reloads only when the previous beat is fully
    // drained, because sink_ready is never high while a word is still pending.
    always_ff @(posedge clock) begin
        if (reset) begin
            held_data  <= '0;
            held_empty <= '0;
            held_sop   <= 1'b0;
            held_eop   <= 1'b0;
            held_error <= 1'b0;
        end else if (sink_xfer) begin
            held_data  <= avalonst_sink_data;
            held_empty <= avalonst_sink_empty;
            held_sop   <= avalonst_sink_startofpacket;
            held_eop   <= avalonst_sink_endofpacket;
            held_error <= avalonst_sink_error;
        end
    end

    // Next-state and output decode. sink_ready looks at source_ready only when
    // the current word is the last one of the held beat. In that case the new
    // beat replaces the held beat on the same edge the last word leaves.
    always_comb begin
        state_next                    = state;
        avalonst_sink_ready           = 1'b0;
        avalonst_source_valid         = 1'b0;
        avalonst_source_data          = '0;
        avalonst_source_startofpacket = 1'b0;
        avalonst_source_endofpacket   = 1'b0;
        avalonst_source_empty         = 1'b0;

        unique case (state)
            EMPTY: begin
                avalonst_sink_ready = 1'b1;
                if (sink_xfer) begin
                    state_next = HI;
                end
            end
            HI: begin
                avalonst_source_valid         = 1'b1;
                avalonst_source_data          = held_data[127:64];
                avalonst_source_startofpacket = held_sop;
                avalonst_source_endofpacket   = single_out;
                avalonst_source_empty         = single_out && held_empty[0];
                avalonst_sink_ready           = single_out && avalonst_source_ready;
                if (source_xfer) begin
                    if (!single_out) begin
                        state_next = LO;
                    end else if (sink_xfer) begin
                        state_next = HI;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            LO: begin
                avalonst_source_valid         = 1'b1;
                avalonst_source_data          = held_data[63:0];
                avalonst_source_startofpacket = 1'b0;
                avalonst_source_endofpacket   = held_eop;
                avalonst_source_empty         = held_eop && held_empty[0];
                avalonst_sink_ready           = avalonst_source_ready;
                if (source_xfer) begin
                    state_next = sink_xfer ? HI : EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase

        // Nothing is accepted while reset is asserted.
        if (reset) begin
            avalonst_sink_ready = 1'b0;
        end
    end

    // Error is reported only on the word that closes the packet.
    assign avalonst_source_error = held_error && avalonst_source_endofpacket;

`ifdef SONIC_VC_TX_PKT_CNT_EN
    logic [31:0] pkt_count_q;

    // Counts emitted packets. The counter wraps naturally at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_count_q <= '0;
        end else if (source_xfer && avalonst_source_endofpacket) begin
            pkt_count_q <= pkt_count_q + 32'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`else
    assign pkt_count = 32'd0;
`endif

endmodule
